uart_tx_fifo_feeder: RTL and testbench

Byte buffer and launch sequencer directly upstream of the UART transmit core. Producers (classifier result formatter, debug logic) push bytes at clock rate. The block queues them and issues one start strobe per byte to the transmit core, then waits for that core's busy cycle to complete before launching the next byte. It isolates bursty producers from the 9600-baud serial line.

---
 rtl/uart_tx_fifo_feeder_pkg.sv | 24 ++
 rtl/uart_tx_fifo_feeder_if.sv | 32 +++
 rtl/uart_tx_fifo_feeder_sync_fifo.sv | 81 ++++++++
 rtl/uart_tx_fifo_feeder.sv | 92 +++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_feeder_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder_pkg
//   Shared definitions for the UART transmit feeder: default data/depth
//   parameters and the launch-sequencer state encoding.
// -----------------------------------------------------------------------------
package uart_tx_fifo_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  // Fixed 2-bit encodings, kept visible so they read the same in waveforms.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_fifo_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder_if
//   Bundles the producer push side, the FIFO status, the transmit-core
//   handshake and the sticky error flags of the feeder.
//   slave  : the feeder (takes wr_en/wr_data/tx_busy, drives everything else)
//   master : the surroundings (producers plus transmit core)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_busy;
  logic                  overflow;
  logic                  timeout_err;

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, level, tx_start, tx_data, overflow, timeout_err
  );

  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, level, tx_start, tx_data, overflow, timeout_err
  );
endinterface

// File: rtl/uart_tx_fifo_feeder_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder_sync_fifo
//   Single-clock circular byte buffer for the feeder.
//   clk, reset : clock, asynchronous active-low reset
//   wr_en/wr_data : push request (dropped and flagged when full)
//   rd_en/rd_data : pop request / head entry (rd_data is combinational)
//   full, empty, level : registered occupancy status after the current edge
//   overflow : sticky, a push was attempted while full
// -----------------------------------------------------------------------------
module uart_tx_fifo_feeder_sync_fifo
  import uart_tx_fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic [DEPTH_LOG2:0]   level_next;

  // full/empty are the pre-edge flags, so a push while full is rejected even
  // when the same edge pops.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns level_next and no latch forms.
    level_next = level;
    if (push && !pop) begin
      level_next = level + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level - LVL_ONE;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && full) overflow <= 1'b1;
      level <= level_next;
      full  <= (level_next == FULL_LEVEL);
      empty <= (level_next == '0);
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read once the
  // pointers say they were written, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder
//   Queues bytes from bursty producers and launches them one at a time into
//   the UART transmit core, waiting for each busy period to finish.
//   clk   : system clock
//   reset : asynchronous active-low reset (discards queued bytes)
//   bus   : slave side of uart_tx_fifo_feeder_if (push port, FIFO status,
//           tx_start/tx_data/tx_busy handshake, overflow/timeout_err flags)
// -----------------------------------------------------------------------------
module uart_tx_fifo_feeder
  import uart_tx_fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  reset,
  uart_tx_fifo_feeder_if.slave bus
);

  localparam int               CNT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  feeder_state_e         state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;

  // The head byte leaves the FIFO at the edge that ends the launch cycle.
  assign pop = (state == LAUNCH);

  uart_tx_fifo_feeder_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (bus.full),
    .empty    (bus.empty),
    .level    (bus.level),
    .overflow (bus.overflow)
  );

  // tx_start/tx_data are loaded on the transition into LAUNCH so the strobe
  // is high for exactly the LAUNCH cycle and the byte is already stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.empty) begin
            state        <= LAUNCH;
            bus.tx_start <= 1'b1;
            bus.tx_data  <= head;
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            // The core never acknowledged; the byte is lost, move on.
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_feeder
//   Self-checking bench: a transaction-level model (byte queue plus a launch
//   window described in cycles) predicts every output each cycle, a small
//   transmit-core emulation answers tx_start with a busy pulse, and directed
//   checks pin latency, ordering, overflow, timeout and async reset.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_feeder;
  import uart_tx_fifo_feeder_pkg::*;

  localparam int DW           = 8;
  localparam int DL           = 4;
  localparam int DEPTH        = 1 << DL;
  localparam int BUSY_TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_tx_fifo_feeder_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo_feeder #(
    .DATA_WIDTH   (DW),
    .DEPTH_LOG2   (DL),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transmit-core emulation ----------------
  bit core_en     = 1'b1;
  int rise_dly    = 2;
  int busy_len    = 1000;
  bit core_active = 1'b0;
  int core_cnt    = 0;

  always @(negedge clk) begin
    if (!reset) begin
      core_active = 1'b0;
      core_cnt    = 0;
      bus.tx_busy = 1'b0;
    end else if (core_active) begin
      core_cnt++;
      if (core_cnt >= rise_dly + busy_len) begin
        bus.tx_busy = 1'b0;
        core_active = 1'b0;
      end else begin
        bus.tx_busy = (core_cnt >= rise_dly);
      end
    end else if (bus.tx_start && core_en) begin
      core_active = 1'b1;
      core_cnt    = 0;
    end
  end

  // ---------------- behavioural model ----------------
  // A byte is "in flight" from its strobe until the core's busy pulse ends,
  // or until BUSY_TIMEOUT cycles pass after the strobe without busy.
  logic [DW-1:0] mq[$];
  logic          m_start;
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_tmo;
  bit            in_flight;
  bit            acked;
  int            unacked_cycles;
  bit            t_full;
  bit            t_launch;
  logic [DW-1:0] t_head;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_start   = 1'b0;
      m_data    = '0;
      m_ovf     = 1'b0;
      m_tmo     = 1'b0;
      in_flight = 1'b0;
      acked     = 1'b0;
      unacked_cycles = 0;
    end else begin
      t_full   = (mq.size() == DEPTH);
      t_launch = !in_flight && !m_start && (mq.size() != 0);
      t_head   = (mq.size() != 0) ? mq[0] : '0;
      if (m_start) begin
        in_flight = 1'b1;
        acked     = 1'b0;
        unacked_cycles = 0;
      end else if (in_flight) begin
        if (!acked) begin
          if (bus.tx_busy) begin
            acked = 1'b1;
          end else begin
            unacked_cycles++;
            if (unacked_cycles == BUSY_TIMEOUT) begin
              m_tmo     = 1'b1;
              in_flight = 1'b0;
            end
          end
        end else if (!bus.tx_busy) begin
          in_flight = 1'b0;
        end
      end
      if (m_start) void'(mq.pop_front());
      if (bus.wr_en) begin
        if (t_full) m_ovf = 1'b1;
        else        mq.push_back(bus.wr_data);
      end
      m_start = t_launch;
      if (t_launch) m_data = t_head;
    end
  end

  // ---------------- per-cycle compare ----------------
  int            n_strobes = 0;
  logic [DW-1:0] strobe_log[$];

  always @(negedge clk) begin
    check("tx_start",      bus.tx_start,    m_start);
    check("tx_data",       bus.tx_data,     m_data);
    check("level",         bus.level,       mq.size());
    check("full",          bus.full,        mq.size() == DEPTH);
    check("empty",         bus.empty,       mq.size() == 0);
    check("overflow",      bus.overflow,    m_ovf);
    check("timeout_err",   bus.timeout_err, m_tmo);
    check("start_vs_busy", bus.tx_start & bus.tx_busy, 1'b0);
    if (bus.tx_start === 1'b1) begin
      n_strobes++;
      strobe_log.push_back(bus.tx_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [DW-1:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = first + DW'(i);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 30000) begin
      tick();
      cyc++;
      done = bus.empty && !core_active && !bus.tx_start;
    end
    repeat (BUSY_TIMEOUT + 8) tick();
    check(name, done, 1'b1);
  endtask

  task automatic wait_strobe(input string name);
    int cyc;
    cyc = 0;
    while (bus.tx_start !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check(name, bus.tx_start, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int cnt;
    int pct;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    // 1: reset, then idle with no pushes
    repeat (5) tick();
    reset = 1'b1;
    base  = n_strobes;
    repeat (100) tick();
    check("idle_strobes", n_strobes - base, 0);
    check("idle_empty",   bus.empty, 1'b1);
    check("idle_level",   bus.level, 0);

    // 2: single byte, long busy
    rise_dly = 2; busy_len = 1000;
    base = n_strobes;
    bus.wr_en = 1'b1; bus.wr_data = 8'h41;
    tick();
    bus.wr_en = 1'b0;
    check("lat_empty_after_push", bus.empty, 1'b0);
    check("lat_no_early_strobe",  bus.tx_start, 1'b0);
    tick();
    check("lat_strobe",  bus.tx_start, 1'b1);
    check("lat_tx_data", bus.tx_data, 8'h41);
    wait_drain("drain_single");
    check("single_strobes", n_strobes - base, 1);
    check("single_empty",   bus.empty, 1'b1);

    // 3: burst of 16 bytes leaves in order
    busy_len = 40;
    base = strobe_log.size();
    push_seq(8'h00, 16);
    check("burst_level_after_16", bus.level, 15);
    check("burst_full_after_16",  bus.full, 1'b0);
    wait_drain("drain_burst");
    check("burst_strobes", strobe_log.size() - base, 16);
    for (int i = 0; i < 16; i++)
      check("burst_order", (base + i < strobe_log.size()) ? strobe_log[base + i] : 8'hxx, i);

    // 4: overflow while full, then push+pop at level 5
    busy_len = 200;
    base = strobe_log.size();
    push_seq(8'h20, 17);
    check("fill_full",  bus.full, 1'b1);
    check("fill_level", bus.level, DEPTH);
    bus.wr_en = 1'b1; bus.wr_data = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_flag",  bus.overflow, 1'b1);
    check("ovf_level", bus.level, DEPTH);
    cnt = 0;
    while (!(bus.tx_start === 1'b1 && bus.level == 5) && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("reach_level5", bus.level, 5);
    bus.wr_en = 1'b1; bus.wr_data = 8'hC5;
    tick();
    bus.wr_en = 1'b0;
    check("pushpop_level", bus.level, 5);
    wait_drain("drain_ovf");
    check("ovf_strobes", strobe_log.size() - base, 18);
    for (int i = 0; i < 18; i++)
      check("ovf_order", (base + i < strobe_log.size()) ? strobe_log[base + i] : 8'hxx,
            (i == 17) ? 8'hC5 : 8'h20 + i);

    // 5: core never answers -> timeout, then a normal launch
    core_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    wait_strobe("tmo_strobe");
    check("tmo_strobe_data", bus.tx_data, 8'h55);
    cnt = 0;
    while (bus.timeout_err !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    // Strobe is sampled one edge before it falls; the error rises
    // BUSY_TIMEOUT edges after the fall.
    check("tmo_delay", cnt, BUSY_TIMEOUT + 1);
    core_en = 1'b1; busy_len = 30;
    bus.wr_en = 1'b1; bus.wr_data = 8'h66;
    tick();
    bus.wr_en = 1'b0;
    wait_strobe("after_tmo_strobe");
    check("after_tmo_data", bus.tx_data, 8'h66);
    wait_drain("drain_tmo");

    // 6: async reset during a busy period with 3 bytes queued
    busy_len = 100;
    push_seq(8'h71, 4);
    cnt = 0;
    while (bus.tx_busy !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    tick();
    check("rst_pre_level", bus.level, 3);
    reset = 1'b0;
    #1;
    check("rst_tx_start",    bus.tx_start, 1'b0);
    check("rst_tx_data",     bus.tx_data, 8'h00);
    check("rst_level",       bus.level, 0);
    check("rst_empty",       bus.empty, 1'b1);
    check("rst_full",        bus.full, 1'b0);
    check("rst_overflow",    bus.overflow, 1'b0);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    base  = n_strobes;
    repeat (60) tick();
    check("post_rst_strobes", n_strobes - base, 0);

    // Random traffic against the model
    for (int r = 0; r < 4; r++) begin
      rise_dly = $urandom_range(1, 6);
      busy_len = $urandom_range(1, 25);
      core_en  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       pct = 5;
        1:       pct = 30;
        default: pct = 80;
      endcase
      repeat (1500) begin
        bus.wr_en   = ($urandom_range(0, 99) < pct);
        bus.wr_data = DW'($urandom);
        tick();
      end
      bus.wr_en = 1'b0;
      core_en   = 1'b1;
      wait_drain("drain_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
